// File: rtl/acc_collect.sv
`timescale 1ns/1ps
// Accumulates partial-sum rows across K-tiles into ping-pong banks and drains full banks to ppu.
// The start pulse comes 2 cycles after the last row, and the AD rows follow back-to-back; the drain period is AD+1.
// Backpressure: o_psum_ready drops only while the write bank is still full. It returns the cycle after its drain ends.
//
// Ports:
//   i_clk, i_rst            single clock, synchronous active-high reset
//   i_psum_valid/o_psum_ready   partial-sum row handshake
//   i_psum_data             VL lanes of PSUM_W signed partial sums
//   i_psum_first/last       first K-tile row overwrites; a last K-tile row at AD-1 completes the bank
//   o_ppu_start             one-cycle pulse before each drained tile
//   o_acc_data/o_acc_valid  registered accumulator rows, zero when not valid
//   o_busy                  any bank filling, full or draining
// Build option: define ACC_COLLECT_SAT_EN for saturating accumulation (default wraps).
module acc_collect #(
    parameter int VL     = 16,
    parameter int AD     = 16,
    parameter int PSUM_W = 24,
    parameter int ACC_W  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_psum_valid,
    output logic                  o_psum_ready,
    input  logic [PSUM_W*VL-1:0]  i_psum_data,
    input  logic                  i_psum_first,
    input  logic                  i_psum_last,
    output logic                  o_ppu_start,
    output logic [ACC_W*VL-1:0]   o_acc_data,
    output logic                  o_acc_valid,
    output logic                  o_busy
);

    localparam int RW = (AD > 1) ? $clog2(AD) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(AD - 1);

`ifdef ACC_COLLECT_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        D_IDLE,
        D_START,
        D_STREAM
    } drain_state_t;

    // Bank storage is never reset; the first K-tile row always overwrites it.
    logic [ACC_W*VL-1:0] bank_mem [2][AD];

    logic [1:0]     full;
    logic           wbank;
    logic           rbank;
    logic [RW-1:0]  wr_row;
    logic [RW-1:0]  rd_row;
    logic [RW-1:0]  rd_next;
    drain_state_t   state;

    logic                wr_fire;
    logic [ACC_W*VL-1:0] wr_old;
    logic [ACC_W*VL-1:0] wr_new;

    function automatic logic [ACC_W-1:0] lane_update(
        input logic [ACC_W-1:0]  old_val,
        input logic [PSUM_W-1:0] psum_val,
        input logic              overwrite
    );
        logic signed [ACC_W-1:0] ext;
`ifdef ACC_COLLECT_SAT_EN
        logic signed [ACC_W:0]   sum;
`endif
        ext = ACC_W'(signed'(psum_val));
        if (overwrite) begin
            return ext;
        end
`ifdef ACC_COLLECT_SAT_EN
        // One guard bit: the top two bits disagree exactly on signed overflow.
        sum = (ACC_W+1)'(signed'(old_val)) + (ACC_W+1)'(ext);
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            return sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        return sum[ACC_W-1:0];
`else
        return old_val + ext;
`endif
    endfunction

    assign o_psum_ready = !full[wbank];
    assign wr_fire      = i_psum_valid && o_psum_ready;
    assign wr_old       = bank_mem[wbank][wr_row];
    assign rd_next      = rd_row + 1'b1;
    assign o_busy       = (|full) | (wr_row != '0) | (state != D_IDLE);

    always_comb begin
        wr_new = '0;
        for (int g = 0; g < VL; g++) begin
            wr_new[g*ACC_W +: ACC_W] = lane_update(wr_old[g*ACC_W +: ACC_W],
                                                   i_psum_data[g*PSUM_W +: PSUM_W],
                                                   i_psum_first);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_fire) begin
            bank_mem[wbank][wr_row] <= wr_new;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            full        <= '0;
            wbank       <= 1'b0;
            rbank       <= 1'b0;
            wr_row      <= '0;
            rd_row      <= '0;
            state       <= D_IDLE;
            o_ppu_start <= 1'b0;
            o_acc_valid <= 1'b0;
            o_acc_data  <= '0;
        end else begin
            // Write side: never targets the draining bank, since that bank stays full.
            if (wr_fire) begin
                wr_row <= (wr_row == LAST_ROW) ? '0 : wr_row + 1'b1;
                if (wr_row == LAST_ROW && i_psum_last) begin
                    full[wbank] <= 1'b1;
                    wbank       <= ~wbank;
                end
            end

            o_ppu_start <= 1'b0;
            o_acc_valid <= 1'b0;
            o_acc_data  <= '0;

            // Output rows are registered, so each cycle loads the row shown next cycle.
            case (state)
                D_IDLE: begin
                    if (full[rbank]) begin
                        state       <= D_START;
                        o_ppu_start <= 1'b1;
                    end
                end
                D_START: begin
                    state       <= D_STREAM;
                    rd_row      <= '0;
                    o_acc_valid <= 1'b1;
                    o_acc_data  <= bank_mem[rbank][0];
                end
                D_STREAM: begin
                    if (rd_row == LAST_ROW) begin
                        full[rbank] <= 1'b0;
                        rbank       <= ~rbank;
                        rd_row      <= '0;
                        if (full[~rbank]) begin
                            state       <= D_START;
                            o_ppu_start <= 1'b1;
                        end else begin
                            state <= D_IDLE;
                        end
                    end else begin
                        rd_row      <= rd_next;
                        o_acc_valid <= 1'b1;
                        o_acc_data  <= bank_mem[rbank][rd_next];
                    end
                end
                default: state <= D_IDLE;
            endcase
        end
    end

endmodule

// File: doc/acc_collect.md
# acc_collect

Upstream stage of the post-processing unit (`ppu`). It takes raw partial-sum rows from the systolic array and accumulates them across K-tiles into a ping-pong pair of `AD × VL` banks. It then drains each completed bank to `ppu` as an `i_ppu_start` pulse followed by `AD` back-to-back accumulator vectors. While one bank drains, the other fills, so the array never stalls unless both banks are full.

## Interface
- `VL`, 16: lanes per vector.
- `AD`, 16: rows per tile, and vectors per `ppu` start.
- `PSUM_W`, 24: signed partial-sum width per lane.
- `ACC_W`, 32: signed accumulator width per lane; must be ≥ `PSUM_W`.

Ports (clock and reset first):
- `i_clk`  in  1  single clock; all logic on its rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_psum_valid`  in  1  partial-sum row valid.
- `o_psum_ready`  out  1  write side can accept a row.
- `i_psum_data`  in  `PSUM_W*VL`  one partial-sum row; lane `g` is at `[g*PSUM_W +: PSUM_W]`.
- `i_psum_first`  in  1  row belongs to the first K-tile: overwrite instead of accumulate.
- `i_psum_last`  in  1  row belongs to the last K-tile: bank completes after row `AD-1`.
- `o_ppu_start`  out  1  one-cycle start pulse to `ppu`.
- `o_acc_data`  out  `ACC_W*VL`  accumulator vector to `ppu` `i_acc_data`.
- `o_acc_valid`  out  1  `o_acc_data` carries a live row.
- `o_busy`  out  1  any bank filling, full or draining.

## Operation
- Storage: two banks, each with `AD` entries of `ACC_W*VL` bits, implemented as a register array with combinational read.
- Per-bank flags: `full[b]`. Pointers: `wbank` (bank being filled) and `rbank` (bank to drain next). Counters: `wr_row` and `rd_row`, each 0..`AD-1`.
- Write handshake: a row is accepted when `i_psum_valid && o_psum_ready`.
  - `o_psum_ready = !full[wbank]`, computed from registered state only.
- On an accepted row, for each lane:
  - if `i_psum_first`: `bank[wbank][wr_row] = sign_extend(psum)`.
  - otherwise: `bank[wbank][wr_row] += sign_extend(psum)`.
- `wr_row` wraps from `AD-1` to 0.
  - If the row accepted at `wr_row == AD-1` has `i_psum_last` set: set `full[wbank]` and toggle `wbank`.
- `i_psum_first` and `i_psum_last` are sampled per row. Both set at once means a single-K-tile matrix: overwrite, then complete.
- Drain FSM states:
  - `D_IDLE`: if `full[rbank]`, go to `D_START`.
  - `D_START`: `o_ppu_start=1`, `rd_row=0`; go to `D_STREAM`.
  - `D_STREAM`: one row per cycle for `AD` cycles.
    - On the cycle `rd_row==AD-1`: clear `full[rbank]` and toggle `rbank`.
    - Then go to `D_START` if the other bank is full, else `D_IDLE`.
- `o_acc_data` is registered and loaded with `bank[rbank][rd_row]` for each streaming row. It is zero whenever `o_acc_valid=0`.
- `o_busy = full[0] | full[1] | (wr_row != 0) | (state != D_IDLE)`.

## Timing
- Reset: `o_psum_ready=1` (it is combinational from the cleared flags), `o_ppu_start=0`, `o_acc_valid=0`, `o_acc_data=0`, `o_busy=0`. Also cleared: flags, pointers, counters, FSM state (`D_IDLE`). Bank contents are not reset.
- Reset mid-operation drops every partial and full bank. The first row after reset must carry `i_psum_first`.
- Fill-to-start latency: if row `AD-1` is accepted with `last` at cycle T and the drain FSM is idle, `o_ppu_start` is high at T+2.
- Drain timing: with start at cycle S, rows 0..`AD-1` appear at S+1..S+`AD` with `o_acc_valid=1`. This matches `ppu` consuming one vector per cycle in the `AD` cycles after start.
- The earliest next `o_ppu_start` is at S+`AD`+1, which is the cycle `ppu` is back in idle. Drain period is `AD`+1 cycles.
- Bank freed while the writer waits: `full` is cleared at the clock edge ending S+`AD`, so `o_psum_ready` rises at S+`AD`+1. There is no same-cycle bypass.
- Write and drain proceed in the same cycle on different banks without interaction. The write side never targets the draining bank, because that bank stays full until the drain completes.

## Configuration
- `ACC_COLLECT_SAT_EN`:
  - Defined: accumulation saturates to the signed `ACC_W` range. Overflow clamps to `2^(ACC_W-1)-1` or `-2^(ACC_W-1)`.
  - Undefined: accumulation wraps modulo `2^ACC_W`. No saturation logic is built.

## Test plan
- Single K-tile: 16 rows with `first=last=1`, lane value `row*16+lane` → start pulse 2 cycles after the last row; then 16 vectors equal to the input, sign-extended to 32 bits.
- Three K-tiles of all-lanes value −5, 7, 100 → every drained lane equals 102.
- Back-to-back matrices with `i_psum_valid` held high → `o_psum_ready` never drops while a bank is free; starts are spaced exactly 17 cycles apart.
- Both banks full → `o_psum_ready=0`, and a held row is not accepted. Ready returns the cycle after the 16th streamed row; the held row is then written into the freed bank.
- Overflow with `psum=+8388607` over 300 tiles:
  - macro on: lane = 2147483647;
  - macro off: lane = 2516582100 mod 2^32, interpreted as signed.
- Reset asserted mid-drain at row 5 → next cycle `o_acc_valid=0`, `o_acc_data=0`, `o_busy=0`; no further start pulse until a new complete matrix arrives.
